// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pwm_pkg
// Description : Shared constants and types for the PWM duty-cycle controller:
//               PS/2 make codes, preset duty values and the byte-FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package pwm_pkg;

  // PS/2 set-2 make codes recognised by the duty controller
  localparam logic [7:0] SC_F   = 8'h2B;
  localparam logic [7:0] SC_Q   = 8'h15;
  localparam logic [7:0] SC_H   = 8'h33;
  localparam logic [7:0] SC_X   = 8'h22;
  localparam logic [7:0] SC_UP  = 8'h79;
  localparam logic [7:0] SC_DN  = 8'h7B;
  localparam logic [7:0] SC_BRK = 8'hF0;
  localparam logic [7:0] SC_EXT = 8'hE0;

  // Preset duty values loaded verbatim by the preset keys
  localparam int DUTY_F = 41;
  localparam int DUTY_Q = 51;
  localparam int DUTY_H = 61;
  localparam int DUTY_X = 81;

  // Byte-sequencing FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BREAK = 2'd1,
    EXT   = 2'd2
  } state_t;

endpackage : pwm_pkg
`default_nettype wire

// File: rtl/pwm_slew.sv
`default_nettype none
// ============================================================================
// Module      : pwm_slew
// Description : Live duty register. Updates only on PWM period boundaries so
//               the comparator never sees a mid-period change.
//               PWM_RAMP_EN defined   : duty moves one count toward target
//                                       per period_end strobe.
//               PWM_RAMP_EN undefined : duty loads target on the next
//                                       period_end strobe.
// Ports       : clk          - clock
//               rst          - asynchronous active-high reset
//               i_period_end - one-cycle strobe at PWM counter wrap
//               i_target     - requested duty
//               o_duty       - live duty for the comparator
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_slew #(
  parameter int DUTY_W   = 7,
  parameter int DUTY_RST = 41
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_period_end,
  input  logic [DUTY_W-1:0] i_target,
  output logic [DUTY_W-1:0] o_duty
);

  localparam logic [DUTY_W-1:0] c_DUTY_RST = DUTY_W'(DUTY_RST);

  logic [DUTY_W-1:0] r_duty;

`ifdef PWM_RAMP_EN
  localparam logic [DUTY_W-1:0] c_ONE = {{(DUTY_W-1){1'b0}}, 1'b1};

  // A single-count step can never pass the target, so no overshoot check
  // is needed beyond the direction compare.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_duty <= c_DUTY_RST;
    end else if (i_period_end) begin
      if (r_duty < i_target) begin
        r_duty <= r_duty + c_ONE;
      end else if (r_duty > i_target) begin
        r_duty <= r_duty - c_ONE;
      end
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_duty <= c_DUTY_RST;
    end else if (i_period_end) begin
      r_duty <= i_target;
    end
  end
`endif

  assign o_duty = r_duty;

endmodule : pwm_slew
`default_nettype wire

// File: rtl/pwm_duty_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pwm_duty_ctrl
// Description : Duty-cycle setpoint sequencer between the PS/2 receiver and
//               the PWM counter/comparator. Filters break (F0) and extended
//               (E0) sequences, maps make codes to a target duty, and slews
//               the live duty toward it on PWM period boundaries.
//               Build option: PWM_RAMP_EN selects +/-1 per period slewing;
//               without it duty jumps to target at the next period boundary.
// Ports       : clkdiv4    - clock, all state on rising edge
//               reset      - asynchronous active-high reset
//               scancode   - PS/2 byte, qualified by scan_valid
//               scan_valid - one-cycle strobe for a new byte
//               period_end - one-cycle strobe at PWM counter wrap
//               duty       - live duty for the comparator
//               target     - requested duty
//               busy       - registered (duty != target)
//               key_err    - one-cycle pulse on an unmapped make code
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_duty_ctrl #(
  parameter int DUTY_W   = 7,
  parameter int DUTY_RST = 41,
  parameter int DUTY_MIN = 1,
  parameter int DUTY_MAX = 100,
  parameter int STEP     = 5
) (
  input  logic              clkdiv4,
  input  logic              reset,
  input  logic [7:0]        scancode,
  input  logic              scan_valid,
  input  logic              period_end,
  output logic [DUTY_W-1:0] duty,
  output logic [DUTY_W-1:0] target,
  output logic              busy,
  output logic              key_err
);

  import pwm_pkg::*;

  localparam logic [DUTY_W-1:0] c_DUTY_RST = DUTY_W'(DUTY_RST);
  localparam logic [DUTY_W-1:0] c_MIN      = DUTY_W'(DUTY_MIN);
  localparam logic [DUTY_W-1:0] c_MAX      = DUTY_W'(DUTY_MAX);
  localparam logic [DUTY_W-1:0] c_STEP     = DUTY_W'(STEP);
  // Thresholds at which an up/down step would cross the clamp; comparing
  // against these avoids overflow of target+STEP in DUTY_W bits.
  localparam logic [DUTY_W-1:0] c_UP_LIM   = DUTY_W'(DUTY_MAX - STEP);
  localparam logic [DUTY_W-1:0] c_DN_LIM   = DUTY_W'(DUTY_MIN + STEP);

  state_t            r_state;
  logic [DUTY_W-1:0] r_target;
  logic              r_busy;
  logic              r_key_err;
  logic [DUTY_W-1:0] w_duty;
  logic [DUTY_W-1:0] w_new_target;
  logic              w_hit;

  // Make-code decode against the current target
  always_comb begin
    w_hit        = 1'b1;
    w_new_target = r_target;
    case (scancode)
      SC_F:    w_new_target = DUTY_W'(DUTY_F);
      SC_Q:    w_new_target = DUTY_W'(DUTY_Q);
      SC_H:    w_new_target = DUTY_W'(DUTY_H);
      SC_X:    w_new_target = DUTY_W'(DUTY_X);
      SC_UP:   w_new_target = (r_target >= c_UP_LIM) ? c_MAX : (r_target + c_STEP);
      SC_DN:   w_new_target = (r_target <= c_DN_LIM) ? c_MIN : (r_target - c_STEP);
      default: w_hit        = 1'b0;
    endcase
  end

  // Byte FSM with target register and key_err pulse
  always_ff @(posedge clkdiv4 or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_target  <= c_DUTY_RST;
      r_key_err <= 1'b0;
    end else begin
      r_key_err <= 1'b0;
      if (scan_valid) begin
        case (r_state)
          IDLE: begin
            if (scancode == SC_BRK) begin
              r_state <= BREAK;
            end else if (scancode == SC_EXT) begin
              r_state <= EXT;
            end else if (w_hit) begin
              r_target <= w_new_target;
            end else begin
              r_key_err <= 1'b1;
            end
          end
          // Repeated F0 keeps us waiting for the released key's code
          BREAK: begin
            if (scancode != SC_BRK) begin
              r_state <= IDLE;
            end
          end
          // Extended keys are unmapped; only an extended break is tracked
          EXT: begin
            if (scancode == SC_BRK) begin
              r_state <= BREAK;
            end else begin
              r_state <= IDLE;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clkdiv4 or posedge reset) begin
    if (reset) begin
      r_busy <= 1'b0;
    end else begin
      r_busy <= (w_duty != r_target);
    end
  end

  // Slew sees the registered (pre-update) target, so a key arriving with
  // period_end takes effect only at the following period boundary.
  pwm_slew #(
    .DUTY_W   (DUTY_W),
    .DUTY_RST (DUTY_RST)
  ) u_slew (
    .clk          (clkdiv4),
    .rst          (reset),
    .i_period_end (period_end),
    .i_target     (r_target),
    .o_duty       (w_duty)
  );

  assign duty    = w_duty;
  assign target  = r_target;
  assign busy    = r_busy;
  assign key_err = r_key_err;

endmodule : pwm_duty_ctrl
`default_nettype wire

// File: tb/tb_pwm_duty_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pwm_duty_ctrl
// Description : Directed self-checking bench for pwm_duty_ctrl. Expected
//               values depend on whether PWM_RAMP_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_duty_ctrl;

  logic       clkdiv4;
  logic       reset;
  logic [7:0] scancode;
  logic       scan_valid;
  logic       period_end;
  logic [6:0] duty;
  logic [6:0] target;
  logic       busy;
  logic       key_err;

  int n_checks;
  int n_fail;

  pwm_duty_ctrl dut (
    .clkdiv4    (clkdiv4),
    .reset      (reset),
    .scancode   (scancode),
    .scan_valid (scan_valid),
    .period_end (period_end),
    .duty       (duty),
    .target     (target),
    .busy       (busy),
    .key_err    (key_err)
  );

  initial clkdiv4 = 1'b0;
  always #5 clkdiv4 = ~clkdiv4;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clkdiv4);
    #1;
  endtask

  task automatic scan(input logic [7:0] code);
    scancode   = code;
    scan_valid = 1'b1;
    tick();
    scan_valid = 1'b0;
  endtask

  task automatic pend();
    period_end = 1'b1;
    tick();
    period_end = 1'b0;
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    reset      = 1'b1;
    scancode   = 8'h00;
    scan_valid = 1'b0;
    period_end = 1'b0;
    repeat (2) @(posedge clkdiv4);
    #1;
    check("rst_duty", 32'(duty), 41);
    check("rst_target", 32'(target), 41);
    check("rst_busy", 32'(busy), 0);
    check("rst_key_err", 32'(key_err), 0);
    reset = 1'b0;
    tick();

    // Preset 0x22 and full ramp
    scan(8'h22);
    check("x_target", 32'(target), 81);
    check("x_busy_lag", 32'(busy), 0);
    tick();
    check("x_busy", 32'(busy), 1);
    for (int i = 1; i <= 40; i++) begin
      pend();
`ifdef PWM_RAMP_EN
      check("ramp_duty", 32'(duty), 32'(41 + i));
`else
      check("jump_duty", 32'(duty), 81);
`endif
    end
`ifdef PWM_RAMP_EN
    check("ramp_busy_hold", 32'(busy), 1);
`else
    check("jump_busy_clear", 32'(busy), 0);
`endif
    tick();
    check("ramp_busy_drop", 32'(busy), 0);

    // Break and extended filtering
    scan(8'hF0);
    scan(8'h2B);
    check("brk_target", 32'(target), 81);
    check("brk_key_err", 32'(key_err), 0);
    scan(8'h15);
    check("brk_idle", 32'(target), 51);
    scan(8'hE0);
    scan(8'h2B);
    check("ext_discard", 32'(target), 51);
    scan(8'hF0);
    scan(8'hF0);
    scan(8'h2B);
    check("brk_repeat", 32'(target), 51);
    scan(8'h2B);
    check("f_target", 32'(target), 41);

    // Up/down saturation
    scan(8'h22);
    scan(8'h79);
    scan(8'h79);
    scan(8'h79);
    check("up_96", 32'(target), 96);
    scan(8'h79);
    check("up_sat", 32'(target), 100);
    scan(8'h79);
    check("up_sat_hold", 32'(target), 100);
    scan(8'h2B);
    for (int i = 0; i < 7; i++) scan(8'h7B);
    check("dn_6", 32'(target), 6);
    scan(8'h7B);
    check("dn_sat", 32'(target), 1);
    scan(8'h7B);
    check("dn_sat_hold", 32'(target), 1);

    // Unmapped make code
    scan(8'h1C);
    check("err_pulse", 32'(key_err), 1);
    check("err_target", 32'(target), 1);
    tick();
    check("err_clear", 32'(key_err), 0);

    // Key coincident with period_end uses the old target
    scan(8'h2B);
`ifdef PWM_RAMP_EN
    for (int i = 0; i < 36; i++) pend();
    check("pre_coin_duty", 32'(duty), 45);
`else
    check("pre_coin_duty", 32'(duty), 81);
`endif
    scancode   = 8'h15;
    scan_valid = 1'b1;
    period_end = 1'b1;
    tick();
    scan_valid = 1'b0;
    period_end = 1'b0;
    check("coin_target", 32'(target), 51);
`ifdef PWM_RAMP_EN
    check("coin_duty", 32'(duty), 44);
    pend();
    check("coin_next", 32'(duty), 45);
`else
    check("coin_duty", 32'(duty), 41);
    pend();
    check("coin_next", 32'(duty), 51);
`endif

    // Asynchronous reset mid-ramp
    scan(8'h22);
`ifdef PWM_RAMP_EN
    for (int i = 0; i < 15; i++) pend();
    check("pre_rst_duty", 32'(duty), 60);
`endif
    tick();
    check("pre_rst_busy", 32'(busy), 1);
    #3;
    reset = 1'b1;
    #1;
    check("arst_duty", 32'(duty), 41);
    check("arst_target", 32'(target), 41);
    check("arst_busy", 32'(busy), 0);
    tick();
    reset = 1'b0;
    tick();
    check("post_rst_duty", 32'(duty), 41);

    // First period_end after a new target
    scan(8'h22);
    pend();
`ifdef PWM_RAMP_EN
    check("first_pend", 32'(duty), 42);
`else
    check("first_pend", 32'(duty), 81);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_pwm_duty_ctrl
`default_nettype wire
